// File: rtl/positround_sum_es3.sv
// positround_sum_es3: round-to-nearest-even and scale saturation of the raw ES3 adder sum
module positround_sum_es3 #(
    parameter int SUM_W     = 41,
    parameter int OUT_W     = 38,
    parameter int MAX_SCALE = 240
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [SUM_W-1:0] in,
    input  logic             in_truncated,
    output logic [OUT_W-1:0] result,
    output logic             done,
    output logic             truncated
);
    localparam logic signed [9:0] MAX_S = 10'(MAX_SCALE);

    logic [25:0]       kept;
    logic              g, r, s, rup;
    logic              v1, v2;
    logic              s1_sgn, s1_inexact, s1_cancel, s1_inf, s1_zero, s1_trunc;
    logic signed [9:0] s1_scale;
    logic [26:0]       s1_sum;
    logic signed [9:0] sc, nscale;
    logic              hi, lo, ntrunc;
    logic [25:0]       nfrac;
    logic [OUT_W-1:0]  nres;

    assign kept = in[30:5];
    assign g    = in[4];
    assign r    = in[3];
    assign s    = in[2] | in_truncated;
    assign rup  = g & (r | s | kept[0]);
    assign done = v2;

    // Stage 1: round the kept fraction and classify the operand
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1         <= 1'b0;
            s1_sgn     <= 1'b0;
            s1_scale   <= '0;
            s1_sum     <= '0;
            s1_inexact <= 1'b0;
            s1_cancel  <= 1'b0;
            s1_inf     <= 1'b0;
            s1_zero    <= 1'b0;
            s1_trunc   <= 1'b0;
        end else begin
            v1 <= 1'b0;
            if (start) begin
                v1         <= 1'b1;
                s1_sgn     <= in[40];
                s1_scale   <= {in[39], in[39:31]};
                s1_sum     <= {1'b0, kept} + {26'b0, rup};
                s1_inexact <= g | r | s;
                s1_cancel  <= (in[30:2] == '0) & ~in[1] & ~in[0];
                s1_inf     <= in[1];
                s1_zero    <= in[0];
                s1_trunc   <= in_truncated;
            end
        end
    end

    // Stage 2 combinational: absorb rounding carry, saturate, apply special-value priority
    always_comb begin
        sc     = s1_scale + $signed({9'b0, s1_sum[26]});
        hi     = sc > MAX_S;
        lo     = sc < -MAX_S;
        nscale = hi ? MAX_S : lo ? -MAX_S : sc;
        nfrac  = hi ? {26{1'b1}} : (lo | s1_sum[26]) ? 26'b0 : s1_sum[25:0];
        nres   = s1_inf ? OUT_W'(2) : (s1_zero | s1_cancel) ? OUT_W'(1) : {s1_sgn, nscale[8:0], nfrac, 2'b00};
        ntrunc = s1_inf ? 1'b0 : (s1_zero | s1_cancel) ? s1_trunc : s1_inexact | hi | lo;
    end

    // Stage 2 register: output holds while no result is arriving
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v2        <= 1'b0;
            result    <= '0;
            truncated <= 1'b0;
        end else begin
            v2 <= v1;
            if (v1) begin
                result    <= nres;
                truncated <= ntrunc;
            end
        end
    end
endmodule

// File: tb/tb_positround_sum_es3.sv
// tb_positround_sum_es3: directed table, random stream vs arithmetic model, reset flush
module tb_positround_sum_es3;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_truncated = 1'b0;
    logic [40:0] din = '0;
    logic [37:0] result;
    logic        done, truncated;
    int          n_chk = 0, n_pass = 0;
    logic [38:0] expq[$];

    positround_sum_es3 dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in(din), .in_truncated(in_truncated),
        .result(result), .done(done), .truncated(truncated)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [40:0] x;
        logic        it;
        logic [38:0] e;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    function automatic logic [40:0] mk(input bit sg, input int sc, input logic [28:0] f, input bit inf, input bit z);
        return {sg, 9'(sc), f, inf, z};
    endfunction

    function automatic logic [38:0] mko(input bit t, input bit sg, input int sc, input logic [25:0] f, input bit inf, input bit z);
        return {t, sg, 9'(sc), f, inf, z};
    endfunction

    // Arithmetic reference: value-level rounding on the 29b fraction, no bit-field tricks
    function automatic logic [38:0] model(input logic [40:0] x, input logic it);
        int  sc   = $signed(x[39:31]);
        int  f    = int'(x[30:2]);
        int  k    = f / 8;
        int  rem  = f % 8;
        bit  up, sat;
        if (x[1]) return mko(0, 0, 0, 0, 1, 0);
        if (x[0] || f == 0) return mko(it, 0, 0, 0, 0, 1);
        up  = rem > 4 || (rem == 4 && (it || k % 2 == 1));
        k   = k + int'(up);
        if (k == 2 ** 26) begin
            k  = 0;
            sc = sc + 1;
        end
        sat = 0;
        if (sc > 240) begin
            sc = 240; k = 2 ** 26 - 1; sat = 1;
        end else if (sc < -240) begin
            sc = -240; k = 0; sat = 1;
        end
        return mko((rem != 0) || it || sat, x[40], sc, 26'(k), 0, 0);
    endfunction

    function automatic logic [40:0] rnd_in();
        logic [28:0] f = 29'($urandom);
        int          sc = int'($urandom_range(0, 520)) - 260;
        if ($urandom_range(0, 15) == 0) f = '0;
        return mk(1'($urandom), sc, f, $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0);
    endfunction

    // Every done must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (done) begin
            if (expq.size() == 0) chk("unexpected_done", 1, 0);
            else chk("result", {truncated, result}, expq.pop_front());
        end
    end

    task automatic op(input logic [40:0] x, input logic it, input logic [38:0] e);
        @(posedge clk);
        #1 start = 1'b1; din = x; in_truncated = it; expq.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk); chk("done_early", done, 0);
        @(negedge clk); chk("done", done, 1);
        @(negedge clk); chk("done_drop", done, 0);
        chk("hold", {truncated, result}, e);
    endtask

    initial begin
        vec_t tbl[12];
        int   n, run, maxrun;
        tbl[0]  = '{"exact",      mk(0, 3, {26'h1234567, 3'b000}, 0, 0), 0, mko(0, 0, 3, 26'h1234567, 0, 0)};
        tbl[1]  = '{"tie_even",   mk(0, 0, {26'h0000002, 3'b100}, 0, 0), 0, mko(1, 0, 0, 26'h0000002, 0, 0)};
        tbl[2]  = '{"tie_odd",    mk(0, 0, {26'h0000003, 3'b100}, 0, 0), 0, mko(1, 0, 0, 26'h0000004, 0, 0)};
        tbl[3]  = '{"tie_sticky", mk(0, 0, {26'h0000002, 3'b100}, 0, 0), 1, mko(1, 0, 0, 26'h0000003, 0, 0)};
        tbl[4]  = '{"carry",      mk(0, -5, 29'h1FFFFFFF, 0, 0),         0, mko(1, 0, -4, 26'h0, 0, 0)};
        tbl[5]  = '{"sat_carry",  mk(0, 240, 29'h1FFFFFFF, 0, 0),        0, mko(1, 0, 240, 26'h3FFFFFF, 0, 0)};
        tbl[6]  = '{"sat_hi",     mk(0, 250, 29'h0000008, 0, 0),         0, mko(1, 0, 240, 26'h3FFFFFF, 0, 0)};
        tbl[7]  = '{"sat_lo",     mk(1, -250, 29'h0000008, 0, 0),        0, mko(1, 1, -240, 26'h0, 0, 0)};
        tbl[8]  = '{"cancel",     mk(1, 7, 29'h0, 0, 0),                 0, mko(0, 0, 0, 26'h0, 0, 1)};
        tbl[9]  = '{"inf_zero",   mk(1, 5, 29'h0000123, 1, 1),           1, mko(0, 0, 0, 26'h0, 1, 0)};
        tbl[10] = '{"zero_trunc", mk(0, 0, 29'h0, 0, 1),                 1, mko(1, 0, 0, 26'h0, 0, 1)};
        tbl[11] = '{"neg_round",  mk(1, -1, {26'h0000005, 3'b101}, 0, 0), 0, mko(1, 1, -1, 26'h0000006, 0, 0)};
        @(posedge clk);
        #1 start = 1'b1; din = mk(0, 3, 29'h1, 0, 0);
        @(posedge clk);
        @(negedge clk);
        chk("reset_done", done, 0);
        chk("reset_out", {truncated, result}, 0);
        @(posedge clk);
        #1 rst_n = 1'b1; start = 1'b0;
        for (int i = 0; i < 12; i++) op(tbl[i].x, tbl[i].it, tbl[i].e);
        n = 0; run = 0; maxrun = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    logic [40:0] x = rnd_in();
                    logic        it = 1'($urandom);
                    @(posedge clk);
                    #1 start = 1'b1; din = x; in_truncated = it; expq.push_back(model(x, it));
                end
                @(posedge clk);
                #1 start = 1'b0;
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    @(negedge clk);
                    if (done) begin
                        n++; run++;
                        if (run > maxrun) maxrun = run;
                    end else run = 0;
                end
            end
        join
        chk("stream_count", n, 10);
        chk("stream_run", maxrun, 10);
        @(posedge clk);
        #1 start = 1'b1; din = mk(0, 10, 29'h1ABCDEF, 0, 0); in_truncated = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0; din = mk(1, 20, 29'h0ABCDEF, 0, 0);
        @(posedge clk);
        #1 rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        chk("flush_done", done, 0);
        chk("flush_out", {truncated, result}, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("flush_nodone", done, 0);
        end
        op(mk(0, 3, {26'h1234567, 3'b000}, 0, 0), 0, mko(0, 0, 3, 26'h1234567, 0, 0));
        chk("queue_empty", expq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
